// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and types for the nibble-serial subtractor.
// Nibble width, FSM states and an index-width helper.
package nibble_serial_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // A single-nibble datapath still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_sub4.sv
// Combinational 4-bit borrow-lookahead subtractor.
// Computes a + ~b + ~bin; carry-out inverted gives borrow-out.
module nibble_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & ~b;
  assign p = ~(a ^ b);

  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d    = p ^ c[3:0];
  assign bout = ~c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one nibble per clock, LSB first.
// Borrow ripples between nibbles through a flop.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_chk
    $error("WIDTH must be a multiple of 4 and >= 4");
  end

  state_t          state;
  state_t          state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] d_ext;
  logic [IW-1:0]   idx;
  logic            brw;
  logic            a_msb;
  logic            b_msb;
  logic [3:0]      nd;
  logic            nb;
  logic            accept;

  nibble_sub4 u_sub (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .bin  (brw),
    .d    (nd),
    .bout (nb)
  );

  assign accept = in_valid & in_ready;
  assign d_ext  = WIDTH'(nd);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)    state_nx = RUN;
      RUN:  if (idx == LAST) state_nx = DONE;
      DONE: if (out_ready)   state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      idx   <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        brw   <= bin;
        idx   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
        // New nibble enters at the top; nibble 0 lands at the bottom.
        a_sh <= a_sh >> NIBBLE_W;
        b_sh <= b_sh >> NIBBLE_W;
        res  <= (res >> NIBBLE_W)
              | (d_ext << (WIDTH - NIBBLE_W));
        brw  <= nb;
        idx  <= idx + 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = res;
  assign bout      = brw;
  assign ovf       = (a_msb ^ b_msb) & (a_msb ^ res[WIDTH-1]);

endmodule
